// File: rtl/axis_spi_pkg.sv
// Shared types and width helpers for the AXI-Stream to SPI transaction scheduler.
package axis_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT_RX,
        ST_RESP,
        ST_HOLD
    } spi_sched_state_e;

    function automatic int unsigned clog2_ui(input int unsigned v);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < v) w++;
        return w;
    endfunction

    // Index width for N requesters; never zero so a 1-bit index always exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2_ui(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned setup, input int unsigned idle);
        int unsigned m;
        m = (setup > idle) ? setup : idle;
        return clog2_ui(m + 1);
    endfunction

endpackage

// File: rtl/axis_spi_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: first active request at or after ptr wins.
module rr_arbiter
    import axis_spi_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % N_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/axis_spi_sched.sv
// Round-robin scheduler sharing one SPI byte engine among N_REQ AXI-Stream requesters,
// with per-requester chip select, CS setup delay and inter-frame idle gap.
module axis_spi_sched
    import axis_spi_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_IDLE    = 3
) (
    input  logic                        clk_i,
    input  logic                        arstn_i,
    input  logic [N_REQ-1:0]            req_tvalid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_tdata,
    input  logic [N_REQ-1:0]            req_tlast,
    output logic [N_REQ-1:0]            req_tready,
    output logic [N_REQ-1:0]            resp_tvalid,
    output logic [DATA_WIDTH-1:0]       resp_tdata,
    output logic                        resp_tlast,
    input  logic [N_REQ-1:0]            resp_tready,
    output logic                        eng_tx_valid,
    output logic [DATA_WIDTH-1:0]       eng_tx_data,
    input  logic                        eng_tx_ready,
    input  logic                        eng_rx_valid,
    input  logic [DATA_WIDTH-1:0]       eng_rx_data,
    output logic [N_REQ-1:0]            spi_cs_n_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int unsigned IDX_W = idx_width(N_REQ);
    localparam int unsigned CNT_W = cnt_width(CS_SETUP, CS_IDLE);

    spi_sched_state_e state_q, state_d;

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      g_q;
    logic [N_REQ-1:0]      g_oh_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  tlast_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic                  err_q;

    logic [N_REQ-1:0]      arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  tx_hs;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_tvalid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign tx_hs      = req_tvalid[g_q] && eng_tx_ready;
    assign resp_tdata = rx_q;
    assign resp_tlast = tlast_q && (state_q == ST_RESP);
    assign busy_o     = (state_q != ST_IDLE);
    assign err_o      = err_q;

    always_comb begin
        state_d      = state_q;
        req_tready   = '0;
        resp_tvalid  = '0;
        eng_tx_valid = 1'b0;
        eng_tx_data  = req_tdata[32'(g_q)*DATA_WIDTH +: DATA_WIDTH];
        spi_cs_n_o   = '1;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                spi_cs_n_o = ~g_oh_q;
                if (cnt_q == '0) state_d = ST_SEND;
            end
            ST_SEND: begin
                spi_cs_n_o   = ~g_oh_q;
                eng_tx_valid = req_tvalid[g_q];
                req_tready   = g_oh_q & {N_REQ{eng_tx_ready}};
                if (tx_hs) state_d = ST_WAIT_RX;
            end
            ST_WAIT_RX: begin
                spi_cs_n_o = ~g_oh_q;
                if (eng_rx_valid) state_d = ST_RESP;
            end
            ST_RESP: begin
                spi_cs_n_o  = ~g_oh_q;
                resp_tvalid = g_oh_q;
                if (resp_tready[g_q]) state_d = tlast_q ? ST_HOLD : ST_SEND;
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            g_oh_q  <= '0;
            cnt_q   <= '0;
            tlast_q <= 1'b0;
            rx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // A strobe outside WAIT_RX has no owner: flag it and drop the byte.
            if (eng_rx_valid && (state_q != ST_WAIT_RX)) err_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        g_q    <= arb_idx;
                        g_oh_q <= arb_grant;
                        ptr_q  <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        cnt_q  <= CNT_W'(CS_SETUP - 1);
                    end
                end
                ST_SETUP: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                ST_SEND: begin
                    if (tx_hs) tlast_q <= req_tlast[g_q];
                end
                ST_WAIT_RX: begin
                    if (eng_rx_valid) rx_q <= eng_rx_data;
                end
                ST_RESP: begin
                    if (resp_tready[g_q] && tlast_q) cnt_q <= CNT_W'(CS_IDLE - 1);
                end
                ST_HOLD: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_spi_sched.sv
// Scoreboard bench for axis_spi_sched: directed frames, echo-inverting engine model,
// response/grant/CS monitors decoupled from stimulus.
module tb_axis_spi_sched;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CSS = 2;
    localparam int CSI = 3;

    logic            clk = 1'b0;
    logic            arstn_i;
    logic [N-1:0]    req_tvalid;
    logic [N*DW-1:0] req_tdata;
    logic [N-1:0]    req_tlast;
    logic [N-1:0]    req_tready;
    logic [N-1:0]    resp_tvalid;
    logic [DW-1:0]   resp_tdata;
    logic            resp_tlast;
    logic [N-1:0]    resp_tready;
    logic            eng_tx_valid;
    logic [DW-1:0]   eng_tx_data;
    logic            eng_tx_ready;
    logic            eng_rx_valid;
    logic [DW-1:0]   eng_rx_data;
    logic [N-1:0]    spi_cs_n_o;
    logic            busy_o;
    logic            err_o;

    always #5 clk = ~clk;

    axis_spi_sched #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .CS_SETUP   (CSS),
        .CS_IDLE    (CSI)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn_i),
        .req_tvalid   (req_tvalid),
        .req_tdata    (req_tdata),
        .req_tlast    (req_tlast),
        .req_tready   (req_tready),
        .resp_tvalid  (resp_tvalid),
        .resp_tdata   (resp_tdata),
        .resp_tlast   (resp_tlast),
        .resp_tready  (resp_tready),
        .eng_tx_valid (eng_tx_valid),
        .eng_tx_data  (eng_tx_data),
        .eng_tx_ready (eng_tx_ready),
        .eng_rx_valid (eng_rx_valid),
        .eng_rx_data  (eng_rx_data),
        .spi_cs_n_o   (spi_cs_n_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];
    int          exp_grant[$];
    bit gap_en = 1'b0;
    int spur_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int low_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (!v[i]) return i;
        return -1;
    endfunction

    function automatic int high_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Engine model: accepts every byte, returns its inverse two cycles later.
    initial begin
        int spur_done;
        logic [DW-1:0] b;
        spur_done    = 0;
        eng_rx_valid = 1'b0;
        eng_rx_data  = '0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_done) begin
                @(posedge clk); #1;
                eng_rx_valid = 1'b1;
                eng_rx_data  = 8'h77;
                @(posedge clk); #1;
                eng_rx_valid = 1'b0;
                spur_done++;
            end else if (eng_tx_valid && eng_tx_ready && arstn_i) begin
                b = eng_tx_data;
                @(posedge clk); #1;
                @(posedge clk); #1;
                eng_rx_valid = 1'b1;
                eng_rx_data  = ~b;
                @(posedge clk); #1;
                eng_rx_valid = 1'b0;
            end
        end
    end

    // Monitor: response scoreboard, CS one-hot, grant order and inter-frame gap.
    initial begin
        logic [N-1:0] prev_cs;
        logic [11:0]  e;
        logic [2:0]   ri;
        int gap;
        bit armed;
        prev_cs = '1;
        gap     = 0;
        armed   = 1'b0;
        forever begin
            @(negedge clk);
            if ((resp_tvalid & resp_tready) != '0) begin
                ri = 3'(high_idx(resp_tvalid));
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_unexpected: got req %0d data %0h, required none", ri, resp_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp", {20'd0, ri, resp_tdata, resp_tlast}, {20'd0, e});
                end
            end
            chk("cs_onehot", 32'((spi_cs_n_o == '1) || ($countones(~spi_cs_n_o) == 1)), 32'd1);
            if (prev_cs == '1 && spi_cs_n_o != '1) begin
                if (exp_grant.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL grant_unexpected: got %0d, required none", low_idx(spi_cs_n_o));
                end else begin
                    chk("grant", 32'(low_idx(spi_cs_n_o)), 32'(exp_grant.pop_front()));
                end
                if (gap_en && armed) chk("cs_gap", 32'(gap), 32'(CSI + 1));
                armed = 1'b0;
            end
            if (spi_cs_n_o == '1) begin
                if (prev_cs != '1) begin
                    gap   = 1;
                    armed = gap_en;
                end else begin
                    gap++;
                end
            end
            prev_cs = spi_cs_n_o;
        end
    end

    task automatic send_byte(input int r, input logic [DW-1:0] d, input logic last);
        int t;
        t = 0;
        req_tvalid[r]         = 1'b1;
        req_tdata[r*DW +: DW] = d;
        req_tlast[r]          = last;
        forever begin
            @(negedge clk);
            if (req_tready[r]) begin
                @(posedge clk); #1;
                exp_q.push_back({3'(r), ~d, last});
                break;
            end
            @(posedge clk); #1;
            if (++t > 300) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_timeout: req %0d byte %0h not accepted, required accept", r, d);
                break;
            end
        end
        req_tvalid[r] = 1'b0;
        req_tlast[r]  = 1'b0;
    endtask

    task automatic send_frame(input int r, input int n, input logic [31:0] bytes);
        for (int i = 0; i < n; i++) send_byte(r, bytes[8*i +: 8], i == n - 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: pending %0d busy %0b, required 0 0", exp_q.size(), busy_o);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_cs"},         32'(spi_cs_n_o),   32'hF);
        chk({tag, "_busy"},       32'(busy_o),       32'd0);
        chk({tag, "_err"},        32'(err_o),        32'd0);
        chk({tag, "_tready"},     32'(req_tready),   32'd0);
        chk({tag, "_rvalid"},     32'(resp_tvalid),  32'd0);
        chk({tag, "_txvalid"},    32'(eng_tx_valid), 32'd0);
        chk({tag, "_rdata"},      32'(resp_tdata),   32'd0);
        chk({tag, "_rlast"},      32'(resp_tlast),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn_i      = 1'b0;
        req_tvalid   = '0;
        req_tdata    = '0;
        req_tlast    = '0;
        resp_tready  = '1;
        eng_tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst0");
        @(posedge clk); #1;
        arstn_i = 1'b1;
        @(posedge clk); #1;

        // Four requesters with single-byte frames; requester 0 comes back for a second frame.
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        exp_grant.push_back(0);
        gap_en = 1'b1;
        fork
            begin
                send_frame(0, 1, 32'h10);
                send_frame(0, 1, 32'h14);
            end
            send_frame(1, 1, 32'h11);
            send_frame(2, 1, 32'h12);
            send_frame(3, 1, 32'h13);
        join
        wait_idle();
        gap_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Two-byte frame on requester 0: setup length, CS shape and trailing idle gap.
        exp_grant.push_back(0);
        fork
            send_frame(0, 2, 32'h3CA5);
            begin
                int t;
                int n;
                t = 0;
                n = 0;
                @(negedge clk);
                while (spi_cs_n_o == '1 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                while (!eng_tx_valid && n < 20) begin
                    chk("f1_cs_setup", 32'(spi_cs_n_o), 32'hE);
                    n++;
                    @(negedge clk);
                end
                chk("f1_setup_len", 32'(n), 32'(CSS));
                t = 0;
                while (spi_cs_n_o != '1 && t < 100) begin
                    chk("f1_cs_frame", 32'(spi_cs_n_o), 32'hE);
                    t++;
                    @(negedge clk);
                end
                for (int k = 0; k < CSI + 1; k++) begin
                    chk("f1_cs_hold", 32'(spi_cs_n_o), 32'hF);
                    chk("f1_busy_hold", 32'(busy_o), (k < CSI) ? 32'd1 : 32'd0);
                    @(negedge clk);
                end
            end
        join
        wait_idle();

        // Requester 2 stalls 10 cycles after its first byte.
        exp_grant.push_back(2);
        send_byte(2, 8'h21, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_cs", 32'(spi_cs_n_o), 32'hB);
            chk("stall_txv", 32'(eng_tx_valid), 32'd0);
            @(posedge clk); #1;
        end
        send_byte(2, 8'h22, 1'b0);
        send_byte(2, 8'h23, 1'b1);
        wait_idle();

        // Requester 1 withholds resp_tready for 5 cycles.
        exp_grant.push_back(1);
        resp_tready[1] = 1'b0;
        fork
            send_frame(1, 2, 32'hF00F);
            begin
                int t;
                t = 0;
                while (!resp_tvalid[1] && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_rvalid", 32'(resp_tvalid[1]), 32'd1);
                    chk("bp_rdata", 32'(resp_tdata), 32'hF0);
                    chk("bp_txv", 32'(eng_tx_valid), 32'd0);
                end
                @(posedge clk); #1;
                resp_tready[1] = 1'b1;
            end
        join
        wait_idle();

        // Spurious engine strobe in IDLE, then a normal single-byte frame.
        chk("err_before", 32'(err_o), 32'd0);
        spur_req++;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("err_set", 32'(err_o), 32'd1);
        @(posedge clk); #1;
        exp_grant.push_back(3);
        send_frame(3, 1, 32'h81);
        wait_idle();
        @(negedge clk);
        chk("err_sticky", 32'(err_o), 32'd1);
        @(posedge clk); #1;

        // Reset while the FSM waits in SEND for byte 2 of a 3-byte frame on requester 1.
        exp_grant.push_back(1);
        send_byte(1, 8'h11, 1'b0);
        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_cs", 32'(spi_cs_n_o), 32'hD);
        chk("mid_busy", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        arstn_i = 1'b0;
        @(posedge clk); #1;
        arstn_i = 1'b1;
        chk_reset_vals("rst1");
        @(posedge clk); #1;
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        fork
            send_frame(3, 1, 32'hC3);
            send_frame(0, 1, 32'hC0);
        join
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("grants_left", 32'(exp_grant.size()), 32'd0);
        chk("resp_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
